// File: rtl/port_alloc_sched_if.sv
// Handshake bundle between the router input stage and the port allocation scheduler.
// Statistics outputs exist only when ALLOC_STATS_EN is defined.
interface port_alloc_sched_if #(
    parameter int NUM_PORT = 5,
    parameter int PTR_W    = 3
);
    logic [NUM_PORT-1:0]          valid;
    logic [NUM_PORT*NUM_PORT-1:0] req;
    logic [NUM_PORT-1:0]          avail;
    logic [NUM_PORT*NUM_PORT-1:0] grant;
    logic [NUM_PORT-1:0]          deflect;
    logic [NUM_PORT-1:0]          stall;
    logic [PTR_W-1:0]             prio_ptr;
    logic [NUM_PORT-1:0]          starved;
`ifdef ALLOC_STATS_EN
    logic [15:0]                  defl_total;
    logic [15:0]                  stall_total;
`endif

    modport master (
        output valid, req, avail,
        input  grant, deflect, stall, prio_ptr, starved
`ifdef ALLOC_STATS_EN
        , input defl_total, stall_total
`endif
    );

    modport slave (
        input  valid, req, avail,
        output grant, deflect, stall, prio_ptr, starved
`ifdef ALLOC_STATS_EN
        , output defl_total, stall_total
`endif
    );
endinterface

// File: rtl/port_alloc_sched.sv
// Per-cycle output port allocator for the bufferless router: starved inputs first, then round-robin.
// Optional ALLOC_STATS_EN adds wrapping deflection/stall totals.
module port_alloc_sched #(
    parameter int NUM_PORT     = 5,
    parameter int PTR_W        = 3,
    parameter int STARVE_W     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic                clk,
    input logic                rst_n,
    port_alloc_sched_if.slave  bus
);
    localparam logic [STARVE_W-1:0] CNT_MAX  = '1;
    localparam logic [STARVE_W-1:0] CNT_LIM  = STARVE_W'(STARVE_LIMIT);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(NUM_PORT - 1);

    logic [NUM_PORT*NUM_PORT-1:0] grant_q, grant_d;
    logic [NUM_PORT-1:0]          defl_q, defl_d;
    logic [NUM_PORT-1:0]          stall_q, stall_d;
    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [STARVE_W-1:0]          cnt_q [NUM_PORT];
    logic [STARVE_W-1:0]          cnt_d [NUM_PORT];
    logic [NUM_PORT-1:0]          starved;

    function automatic logic [NUM_PORT-1:0] lowest_bit(input logic [NUM_PORT-1:0] v);
        logic [NUM_PORT-1:0] r;
        logic                found;
        r     = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_PORT; j++) begin
            if (v[j] && !found) begin
                r[j]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            starved[i] = (cnt_q[i] >= CNT_LIM);
        end
    end

    // Slots 0..N-1 visit starved inputs by index; slots N..2N-1 visit the rest from the head.
    always_comb begin
        logic [NUM_PORT-1:0] rem;
        logic [NUM_PORT-1:0] prod;
        logic [NUM_PORT-1:0] pick;
        logic                elig;
        int                  idx;
        rem     = bus.avail;
        grant_d = '0;
        defl_d  = '0;
        stall_d = '0;
        prod    = '0;
        pick    = '0;
        elig    = 1'b0;
        idx     = 0;
        for (int k = 0; k < 2*NUM_PORT; k++) begin
            if (k < NUM_PORT) begin
                idx  = k;
                elig = bus.valid[idx] && starved[idx];
            end else begin
                idx = int'(ptr_q) + k - NUM_PORT;
                if (idx >= NUM_PORT) idx = idx - NUM_PORT;
                elig = bus.valid[idx] && !starved[idx];
            end
            if (elig) begin
                prod = bus.req[idx*NUM_PORT +: NUM_PORT] & rem;
                pick = '0;
                if (|prod) begin
                    pick = lowest_bit(prod);
                end else if (|rem) begin
                    pick        = lowest_bit(rem);
                    defl_d[idx] = 1'b1;
                end else begin
                    stall_d[idx] = 1'b1;
                end
                grant_d[idx*NUM_PORT +: NUM_PORT] = pick;
                rem = rem & ~pick;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|bus.valid) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORT; i++) begin
            cnt_d[i] = '0;
            if (bus.valid[i] && (defl_d[i] || stall_d[i])) begin
                cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            defl_q  <= '0;
            stall_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < NUM_PORT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            grant_q <= grant_d;
            defl_q  <= defl_d;
            stall_q <= stall_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < NUM_PORT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.grant    = grant_q;
    assign bus.deflect  = defl_q;
    assign bus.stall    = stall_q;
    assign bus.prio_ptr = ptr_q;
    assign bus.starved  = starved;

`ifdef ALLOC_STATS_EN
    function automatic logic [15:0] popcnt(input logic [NUM_PORT-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int j = 0; j < NUM_PORT; j++) begin
            n = n + {15'd0, v[j]};
        end
        return n;
    endfunction

    logic [15:0] defl_tot_q, defl_tot_d;
    logic [15:0] stall_tot_q, stall_tot_d;

    // Totals advance on the same edge the matching deflect/stall bits are registered.
    assign defl_tot_d  = defl_tot_q + popcnt(defl_d);
    assign stall_tot_d = stall_tot_q + popcnt(stall_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defl_tot_q  <= '0;
            stall_tot_q <= '0;
        end else begin
            defl_tot_q  <= defl_tot_d;
            stall_tot_q <= stall_tot_d;
        end
    end

    assign bus.defl_total  = defl_tot_q;
    assign bus.stall_total = stall_tot_q;
`endif
endmodule
